// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute/memory boundary: ALU status bit
// positions, exception cause codes and the EX/MEM stage state encoding.
package mips_pkg;

    localparam int ST_ZERO    = 7;
    localparam int ST_OVF     = 6;
    localparam int ST_CARRY   = 5;
    localparam int ST_NEG     = 4;
    localparam int ST_INVADDR = 3;
    localparam int ST_DIVZ    = 2;

    localparam logic [3:0] CAUSE_OV = 4'd12;
    localparam logic [3:0] CAUSE_DZ = 4'd15;

    // Status bits worth remembering for debug: overflow, carry, invalid address, divide-by-zero.
    localparam logic [7:0] STICKY_MASK = 8'b0110_1100;

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } ex_mem_state_t;

endpackage

// File: rtl/ex_exc_detect.sv
// Combinational fault classification of an ALU status word, plus the
// status bits that feed the sticky debug register.
module ex_exc_detect
    import mips_pkg::*;
#(
    parameter int STATUS_W = 8
) (
    input  logic [STATUS_W-1:0] status,
    input  logic                trap_en,
    output logic                fault,
    output logic [3:0]          cause,
    output logic [STATUS_W-1:0] sticky_bits
);

    localparam logic [STATUS_W-1:0] STICKY_M = STATUS_W'(STICKY_MASK);

    assign sticky_bits = status & STICKY_M;

    // Divide-by-zero outranks overflow; invalid address never traps here.
    always_comb begin
        fault = 1'b0;
        cause = 4'd0;
        if (status[ST_DIVZ]) begin
            fault = 1'b1;
            cause = CAUSE_DZ;
        end else if (status[ST_OVF] && trap_en) begin
            fault = 1'b1;
            cause = CAUSE_OV;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with precise exception capture, sticky status
// flags and a saturating exception counter.
//
//   state | meaning
//   RUN   | normal flow, entries accepted when the output slot is free
//   EXC   | exception pending, intake blocked until ack or flush
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STATUS_W   = 8,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [DATA_W-1:0]     in_result,
    input  logic [STATUS_W-1:0]   in_status,
    input  logic                  in_trap_en,
    input  logic                  in_wb_en,
    input  logic [REG_ADDR_W-1:0] in_wb_addr,
    input  logic                  in_mem_rd,
    input  logic                  in_mem_wr,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [STATUS_W-1:0]   out_status,
    output logic                  out_wb_en,
    output logic                  out_mem_rd,
    output logic                  out_mem_wr,
    output logic [REG_ADDR_W-1:0] out_wb_addr,
    output logic                  exc_req,
    output logic [3:0]            exc_cause,
    output logic [DATA_W-1:0]     exc_epc,
    input  logic                  exc_ack,
    output logic [STATUS_W-1:0]   sticky_status,
    input  logic                  sticky_clr,
    output logic [7:0]            exc_count
);

    ex_mem_state_t         state, state_next;
    logic                  accept;
    logic                  fault;
    logic [3:0]            fault_cause;
    logic [STATUS_W-1:0]   sticky_bits;

    ex_exc_detect #(
        .STATUS_W (STATUS_W)
    ) u_exc_detect (
        .status      (in_status),
        .trap_en     (in_trap_en),
        .fault       (fault),
        .cause       (fault_cause),
        .sticky_bits (sticky_bits)
    );

    assign in_ready = (state == RUN) && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign exc_req  = (state == EXC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: if (accept && fault)    state_next = EXC;
            EXC: if (exc_ack || flush)   state_next = RUN;
            default:                     state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_status     <= '0;
            out_wb_en      <= 1'b0;
            out_mem_rd     <= 1'b0;
            out_mem_wr     <= 1'b0;
            out_wb_addr    <= '0;
        end else if (accept && !fault) begin
            out_valid      <= 1'b1;
            out_result     <= in_result;
            out_store_data <= in_store_data;
            out_status     <= in_status;
            out_wb_en      <= in_wb_en;
            out_mem_rd     <= in_mem_rd;
            out_mem_wr     <= in_mem_wr;
            out_wb_addr    <= in_wb_addr;
        end else if (accept || flush || out_ready) begin
            // A faulting entry is dropped here so it never reaches memory or write-back.
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_cause <= 4'd0;
            exc_epc   <= '0;
            exc_count <= 8'd0;
        end else if (accept && fault) begin
            exc_cause <= fault_cause;
            exc_epc   <= in_pc;
            if (exc_count != 8'hFF) begin
                exc_count <= exc_count + 8'd1;
            end
        end
    end

    // Clear and record can coincide: the newly accepted bits survive the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_status <= '0;
        end else if (accept) begin
            sticky_status <= (sticky_clr ? '0 : sticky_status) | sticky_bits;
        end else if (sticky_clr) begin
            sticky_status <= '0;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a transaction-level model pushes expected
// entries/exceptions at each accept, a negedge monitor pops and compares.
module tb_ex_mem_stage;

    localparam int DATA_W     = 32;
    localparam int STATUS_W   = 8;
    localparam int REG_ADDR_W = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_pc = '0;
    logic [DATA_W-1:0]     in_result = '0;
    logic [STATUS_W-1:0]   in_status = '0;
    logic                  in_trap_en = 1'b0;
    logic                  in_wb_en = 1'b0;
    logic [REG_ADDR_W-1:0] in_wb_addr = '0;
    logic                  in_mem_rd = 1'b0;
    logic                  in_mem_wr = 1'b0;
    logic [DATA_W-1:0]     in_store_data = '0;
    logic                  flush = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [DATA_W-1:0]     out_result;
    logic [DATA_W-1:0]     out_store_data;
    logic [STATUS_W-1:0]   out_status;
    logic                  out_wb_en;
    logic                  out_mem_rd;
    logic                  out_mem_wr;
    logic [REG_ADDR_W-1:0] out_wb_addr;
    logic                  exc_req;
    logic [3:0]            exc_cause;
    logic [DATA_W-1:0]     exc_epc;
    logic                  exc_ack = 1'b0;
    logic [STATUS_W-1:0]   sticky_status;
    logic                  sticky_clr = 1'b0;
    logic [7:0]            exc_count;

    ex_mem_stage #(
        .DATA_W     (DATA_W),
        .STATUS_W   (STATUS_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_result      (in_result),
        .in_status      (in_status),
        .in_trap_en     (in_trap_en),
        .in_wb_en       (in_wb_en),
        .in_wb_addr     (in_wb_addr),
        .in_mem_rd      (in_mem_rd),
        .in_mem_wr      (in_mem_wr),
        .in_store_data  (in_store_data),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_status     (out_status),
        .out_wb_en      (out_wb_en),
        .out_mem_rd     (out_mem_rd),
        .out_mem_wr     (out_mem_wr),
        .out_wb_addr    (out_wb_addr),
        .exc_req        (exc_req),
        .exc_cause      (exc_cause),
        .exc_epc        (exc_epc),
        .exc_ack        (exc_ack),
        .sticky_status  (sticky_status),
        .sticky_clr     (sticky_clr),
        .exc_count      (exc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [31:0] store;
        logic [7:0]  status;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic        rd;
        logic        wr;
    } ent_t;

    typedef struct {
        logic [3:0]  cause;
        logic [31:0] epc;
    } exc_t;

    ent_t        exp_q[$];
    exc_t        exc_q[$];
    bit          m_exc = 1'b0;
    int          m_count = 0;
    logic [7:0]  m_sticky = 8'h00;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !m_exc && !flush && (exp_q.size() == 0 || out_ready);
    endfunction

    // Reference model: transaction-level view of what the stage must do.
    always @(posedge clk) begin
        bit   acc;
        bit   dz;
        bit   ov;
        ent_t e;
        exc_t x;
        if (rst) begin
            exp_q.delete();
            exc_q.delete();
            m_exc    = 1'b0;
            m_count  = 0;
            m_sticky = 8'h00;
        end else begin
            acc = in_valid && m_ready();
            dz  = in_status[2];
            ov  = in_status[6] && in_trap_en;
            if (sticky_clr) m_sticky = 8'h00;
            if (acc) m_sticky = m_sticky | (in_status & 8'h6C);
            if (m_exc && (exc_ack || flush)) begin
                m_exc = 1'b0;
                exc_q.delete();
            end
            if (flush) exp_q.delete();
            if (acc) begin
                if (dz || ov) begin
                    x.cause = dz ? 4'd15 : 4'd12;
                    x.epc   = in_pc;
                    exc_q.push_back(x);
                    m_exc = 1'b1;
                    if (m_count < 255) m_count++;
                end else begin
                    e.result  = in_result;
                    e.store   = in_store_data;
                    e.status  = in_status;
                    e.wb_en   = in_wb_en;
                    e.wb_addr = in_wb_addr;
                    e.rd      = in_mem_rd;
                    e.wr      = in_mem_wr;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        ent_t e;
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready()));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("exc_req", 32'(exc_req), 32'(m_exc));
            chk("exc_count", 32'(exc_count), 32'(m_count));
            chk("sticky", 32'(sticky_status), 32'(m_sticky));
            if (exc_req && exc_q.size() != 0) begin
                chk("exc_cause", 32'(exc_cause), 32'(exc_q[0].cause));
                chk("exc_epc", exc_epc, exc_q[0].epc);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_result", out_result, e.result);
                chk("out_store", out_store_data, e.store);
                chk("out_status", 32'(out_status), 32'(e.status));
                chk("out_wb_en", 32'(out_wb_en), 32'(e.wb_en));
                chk("out_wb_addr", 32'(out_wb_addr), 32'(e.wb_addr));
                chk("out_mem_rd", 32'(out_mem_rd), 32'(e.rd));
                chk("out_mem_wr", 32'(out_mem_wr), 32'(e.wr));
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        flush      = 1'b0;
        exc_ack    = 1'b0;
        sticky_clr = 1'b0;
        in_status  = 8'h00;
        in_trap_en = 1'b0;
    endtask

    task automatic set_entry(input logic [31:0] pc, input logic [31:0] res,
                             input logic [7:0] st, input logic trap,
                             input logic [4:0] wa);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_result     = res;
        in_status     = st;
        in_trap_en    = trap;
        in_wb_en      = 1'b1;
        in_wb_addr    = wa;
        in_mem_rd     = 1'b0;
        in_mem_wr     = 1'b0;
        in_store_data = res ^ 32'hA5A5_0000;
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: time limit reached before end of test");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        // Reset state
        rst = 1'b1;
        idle();
        cyc(2);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_exc_req", 32'(exc_req), 0);
        chk("rst_exc_count", 32'(exc_count), 0);
        chk("rst_sticky", 32'(sticky_status), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        cyc();

        // Simple pass-through entry
        out_ready = 1'b1;
        set_entry(32'h0040_0000, 32'h0000_0005, 8'h00, 1'b0, 5'd3);
        cyc();
        idle();
        chk("d1_out_valid", 32'(out_valid), 1);
        chk("d1_out_result", out_result, 32'h5);
        chk("d1_out_wb_en", 32'(out_wb_en), 1);
        chk("d1_exc_req", 32'(exc_req), 0);
        cyc();

        // Trapping overflow
        set_entry(32'h0040_0010, 32'h7FFF_FFFF, 8'h40, 1'b1, 5'd4);
        cyc();
        set_entry(32'h0040_0014, 32'h1, 8'h00, 1'b0, 5'd5);
        chk("d2_exc_req", 32'(exc_req), 1);
        chk("d2_cause", 32'(exc_cause), 12);
        chk("d2_epc", exc_epc, 32'h0040_0010);
        chk("d2_out_valid", 32'(out_valid), 0);
        chk("d2_in_ready", 32'(in_ready), 0);
        cyc(2);
        chk("d2_in_ready_hold", 32'(in_ready), 0);
        idle();
        exc_ack = 1'b1;
        cyc();
        idle();
        chk("d2_exc_req_ack", 32'(exc_req), 0);
        chk("d2_in_ready_run", 32'(in_ready), 1);

        // Divide-by-zero beats overflow; overflow without trap passes
        set_entry(32'h0040_0020, 32'h0, 8'h44, 1'b0, 5'd6);
        cyc();
        idle();
        chk("d3_cause_dz", 32'(exc_cause), 15);
        exc_ack    = 1'b1;
        sticky_clr = 1'b1;
        cyc();
        idle();
        set_entry(32'h0040_0024, 32'h8000_0000, 8'h40, 1'b0, 5'd7);
        cyc();
        idle();
        chk("d3_out_valid", 32'(out_valid), 1);
        chk("d3_exc_req", 32'(exc_req), 0);
        chk("d3_sticky", 32'(sticky_status), 32'h40);
        cyc();

        // Stall for three cycles, then release
        out_ready = 1'b0;
        set_entry(32'h0040_0030, 32'hAAAA_0001, 8'h00, 1'b0, 5'd8);
        cyc();
        set_entry(32'h0040_0034, 32'hBBBB_0002, 8'h00, 1'b0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            chk("d4_in_ready_stall", 32'(in_ready), 0);
            chk("d4_hold_result", out_result, 32'hAAAA_0001);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("d4_in_ready_release", 32'(in_ready), 1);
        cyc();
        idle();
        chk("d4_next_result", out_result, 32'hBBBB_0002);
        chk("d4_next_valid", 32'(out_valid), 1);
        cyc();

        // Flush cancels a pending exception but keeps the count
        set_entry(32'h0040_0040, 32'h0, 8'h04, 1'b0, 5'd1);
        cyc();
        idle();
        chk("d5_exc_req", 32'(exc_req), 1);
        flush = 1'b1;
        cyc();
        idle();
        chk("d5_flush_exc_req", 32'(exc_req), 0);
        chk("d5_count_kept", 32'(exc_count), 3);

        // Counter saturation
        for (int i = 0; i < 300; i++) begin
            set_entry(32'h0050_0000 + 32'(i * 4), 32'h0, 8'h04, 1'b0, 5'd2);
            cyc();
            idle();
            exc_ack = 1'b1;
            cyc();
            idle();
        end
        chk("d5_count_sat", 32'(exc_count), 255);

        // Sticky clear with same-cycle accept
        sticky_clr = 1'b1;
        cyc();
        idle();
        set_entry(32'h0060_0000, 32'h3, 8'h20, 1'b0, 5'd10);
        cyc();
        idle();
        chk("d6_sticky_carry", 32'(sticky_status), 32'h20);
        cyc();
        set_entry(32'h0060_0004, 32'h0, 8'h04, 1'b0, 5'd11);
        sticky_clr = 1'b1;
        cyc();
        idle();
        chk("d6_sticky_clr_accept", 32'(sticky_status), 32'h04);
        exc_ack = 1'b1;
        cyc();
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] st;
            st = 8'($urandom);
            if ($urandom_range(0, 3) != 0) st[2] = 1'b0;
            if ($urandom_range(0, 2) != 0) st[6] = 1'b0;
            rst           = ($urandom_range(0, 299) == 0);
            in_valid      = ($urandom_range(0, 9) < 7);
            in_pc         = $urandom;
            in_result     = $urandom;
            in_status     = st;
            in_trap_en    = 1'($urandom);
            in_wb_en      = 1'($urandom);
            in_wb_addr    = 5'($urandom);
            in_mem_rd     = 1'($urandom);
            in_mem_wr     = 1'($urandom);
            in_store_data = $urandom;
            out_ready     = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 24) == 0);
            exc_ack       = ($urandom_range(0, 2) == 0);
            sticky_clr    = ($urandom_range(0, 19) == 0);
            cyc();
        end
        rst = 1'b0;
        idle();
        out_ready = 1'b1;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
